// File: rtl/pwm_duty_ramp.sv
// Duty-cycle scheduler for the left/right motor PWM generators.
// Accepts target duty pairs over valid/ready and slews each channel toward
// its target by at most STEP per PWM period. Duties change only on the last
// clk of a period, so every PWM period sees a constant duty. estop forces
// both duties (and the stored targets) to zero.
module pwm_duty_ramp #(
    parameter int DATA_W = 10,
    parameter int STEP   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tgt_lft,
    input  logic [DATA_W-1:0] tgt_rght,
    input  logic              tgt_vld,
    output logic              tgt_rdy,
    input  logic              estop,
    output logic [DATA_W-1:0] duty_lft,
    output logic [DATA_W-1:0] duty_rght,
    output logic              ramping,
    output logic              period_tick
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RAMP = 2'd1;
    localparam logic [1:0] STOP = 2'd2;

    // Step size at the one-bit-wider signed width used for the differences.
    localparam logic signed [DATA_W:0] STEP_S = (DATA_W + 1)'(STEP);
    localparam logic [DATA_W-1:0]      STEP_U = DATA_W'(STEP);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DATA_W-1:0] period_cnt;
    logic [DATA_W-1:0] hold_lft;
    logic [DATA_W-1:0] hold_rght;
    logic [DATA_W-1:0] hold_lft_nxt;
    logic [DATA_W-1:0] hold_rght_nxt;
    logic [DATA_W-1:0] duty_lft_nxt;
    logic [DATA_W-1:0] duty_rght_nxt;
    logic              tick_now;
    logic              accept;

    // Move cur toward tgt by at most STEP. The difference is taken one bit
    // wider and signed, so the clamp can never overshoot or wrap: when the
    // remaining distance is within STEP the result lands exactly on tgt.
    function automatic logic [DATA_W-1:0] step_toward(
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] tgt
    );
        logic signed [DATA_W:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP_S)
            step_toward = cur + STEP_U;
        else if (diff < -STEP_S)
            step_toward = cur - STEP_U;
        else
            step_toward = tgt;
    endfunction

    assign tick_now    = &period_cnt;
    assign period_tick = tick_now;
    assign ramping     = (state == RAMP);
    assign accept      = tgt_vld && tgt_rdy;

    // Free-running period counter, kept in lockstep with the PWM generators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            period_cnt <= '0;
        else
            period_cnt <= period_cnt + DATA_W'(1);
    end

    // Next-state, duty and holding-register decisions; estop overrides all.
    always_comb begin
        state_nxt     = state;
        duty_lft_nxt  = duty_lft;
        duty_rght_nxt = duty_rght;
        hold_lft_nxt  = hold_lft;
        hold_rght_nxt = hold_rght;
        if (estop) begin
            state_nxt     = STOP;
            duty_lft_nxt  = '0;
            duty_rght_nxt = '0;
            hold_lft_nxt  = '0;
            hold_rght_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    // A capture here never steps, even on a tick cycle.
                    if (accept) begin
                        hold_lft_nxt  = tgt_lft;
                        hold_rght_nxt = tgt_rght;
                        if ((tgt_lft != duty_lft) || (tgt_rght != duty_rght))
                            state_nxt = RAMP;
                    end
                end
                RAMP: begin
                    if (tick_now) begin
                        duty_lft_nxt  = step_toward(duty_lft, hold_lft);
                        duty_rght_nxt = step_toward(duty_rght, hold_rght);
                        if ((duty_lft_nxt == hold_lft) && (duty_rght_nxt == hold_rght))
                            state_nxt = IDLE;
                    end
                end
                STOP: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Control registers: FSM state and the registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tgt_rdy <= 1'b0;
        end else begin
            state   <= state_nxt;
            tgt_rdy <= (state_nxt == IDLE) && !estop;
        end
    end

    // Duty outputs and accepted targets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_lft  <= '0;
            duty_rght <= '0;
            hold_lft  <= '0;
            hold_rght <= '0;
        end else begin
            duty_lft  <= duty_lft_nxt;
            duty_rght <= duty_rght_nxt;
            hold_lft  <= hold_lft_nxt;
            hold_rght <= hold_rght_nxt;
        end
    end

endmodule
